// File: rtl/reg_burst_pkg.sv
// Shared types and constants for the framed-command register burst master.
// Ports: none (package).
package reg_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_ADDR,
        ST_WDATA,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_REPLY_STATUS,
        ST_REPLY_DATA
    } state_e;

    localparam logic [7:0] STATUS_OK      = 8'h5A;
    localparam logic [7:0] STATUS_BADTYPE = 8'hE1;

    // TYPE byte layout
    localparam int TYPE_WR_BIT  = 0;
    localparam int TYPE_INC_BIT = 1;
    localparam int TYPE_RSV_LSB = 2;
    localparam int TYPE_RSV_MSB = 3;
    localparam int TYPE_CNT_LSB = 4;
    localparam int TYPE_CNT_MSB = 7;

    localparam int MAX_BURST = 16;

endpackage

// File: rtl/reg_burst_manager_timeout.sv
// Mid-frame idle counter: expire_o pulses when en_i has been held without
// clr_i for TIMEOUT cycles. Ports: clk, reset_n, clr_i, en_i, expire_o.
module reg_cmd_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    if (TIMEOUT == 0) begin : g_off
        assign expire_o = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // A clear in the expiry cycle wins: the byte is accepted.
        assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i || !en_i || expire_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/reg_burst_manager.sv
// Host-command register master: parses MAGIC/TYPE/ADDR/DATA byte frames and
// drives a split read/write register bus with bursts and status replies.
// Ports: clk, reset_n; cmd_wr/cmd_in (command bytes in);
// reply_out/reply_rdy/reply_ack/reply_end (reply bytes out);
// reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata (register bus);
// timeout_evt, cmd_dropped (event pulses).
module reg_burst_manager
    import reg_burst_pkg::*;
#(
    parameter int         ADDR_BYTES   = 2,
    parameter int         DATA_BYTES   = 4,
    parameter logic [7:0] MAGIC        = 8'hAA,
    parameter int         READ_LATENCY = 1,
    parameter int         TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_wr,
    input  logic [7:0]              cmd_in,
    output logic [7:0]              reply_out,
    output logic                    reply_rdy,
    input  logic                    reply_ack,
    output logic                    reply_end,
    output logic [8*ADDR_BYTES-1:0] reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    output logic                    reg_wr,
    output logic                    reg_rd,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    output logic                    timeout_evt,
    output logic                    cmd_dropped
);

    localparam int AW  = 8 * ADDR_BYTES;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int ABW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int DBW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int LW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int WCW = $clog2(MAX_BURST);

    state_e         state_q, state_d;
    logic           is_wr_q, is_wr_d;
    logic           inc_q, inc_d;
    logic           err_q, err_d;
    logic [WCW-1:0] cnt_q, cnt_d;
    logic [WCW-1:0] word_q, word_d;
    logic [ABW-1:0] abyte_q, abyte_d;
    logic [DBW-1:0] dbyte_q, dbyte_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [7:0]     status_q, status_d;
    logic           wr_pulse_q, wr_pulse_d;
    logic           last_q, last_d;

    logic           tmo_en;
    logic           tmo_expire;
    logic [DW-1:0]  rd_shift;
    logic           last_byte;
    logic           last_word;

    // Once the final write word is captured, extra bytes are not part of
    // the frame and must not hold the frame open.
    assign tmo_en = (state_q == ST_TYPE) || (state_q == ST_ADDR) ||
                    ((state_q == ST_WDATA) && !last_q);

    reg_cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (cmd_wr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    assign last_byte = (dbyte_q == DBW'(DATA_BYTES - 1));
    assign last_word = (word_q == cnt_q);

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        inc_d      = inc_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        abyte_d    = abyte_q;
        dbyte_d    = dbyte_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        wr_pulse_d = 1'b0;
        last_d     = last_q;

        // Write auto-increment lands on the cycle after the strobe.
        if (wr_pulse_q && inc_q) begin
            addr_d = addr_q + AW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_wr && (cmd_in == MAGIC)) begin
                    state_d = ST_TYPE;
                end
            end
            ST_TYPE: begin
                if (cmd_wr) begin
                    is_wr_d = cmd_in[TYPE_WR_BIT];
                    inc_d   = cmd_in[TYPE_INC_BIT];
                    cnt_d   = cmd_in[TYPE_CNT_MSB:TYPE_CNT_LSB];
                    word_d  = '0;
                    abyte_d = '0;
                    dbyte_d = '0;
                    last_d  = 1'b0;
                    if (cmd_in[TYPE_RSV_MSB:TYPE_RSV_LSB] != 2'b00) begin
                        err_d    = 1'b1;
                        status_d = STATUS_BADTYPE;
                        state_d  = ST_REPLY_STATUS;
                    end else begin
                        err_d    = 1'b0;
                        status_d = STATUS_OK;
                        state_d  = ST_ADDR;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (cmd_wr) begin
                    addr_d  = (addr_q >> 8) | (AW'(cmd_in) << (AW - 8));
                    abyte_d = abyte_q + ABW'(1);
                    if (abyte_q == ABW'(ADDR_BYTES - 1)) begin
                        state_d = is_wr_q ? ST_WDATA : ST_REPLY_STATUS;
                    end
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (last_q) begin
                    // Final strobe is on the bus this cycle.
                    state_d = ST_REPLY_STATUS;
                end else if (cmd_wr) begin
                    wdata_d = (wdata_q >> 8) | (DW'(cmd_in) << (DW - 8));
                    dbyte_d = dbyte_q + DBW'(1);
                    if (last_byte) begin
                        dbyte_d    = '0;
                        wr_pulse_d = 1'b1;
                        if (last_word) begin
                            last_d = 1'b1;
                        end else begin
                            word_d = word_q + WCW'(1);
                        end
                    end
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPLY_STATUS: begin
                if (reply_ack) begin
                    state_d = (is_wr_q || err_q) ? ST_IDLE : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                lat_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_q == LW'(READ_LATENCY - 1)) begin
                    rdata_d = reg_rdata;
                    dbyte_d = '0;
                    state_d = ST_REPLY_DATA;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_REPLY_DATA: begin
                if (reply_ack) begin
                    dbyte_d = dbyte_q + DBW'(1);
                    if (last_byte) begin
                        dbyte_d = '0;
                        if (inc_q) begin
                            addr_d = addr_q + AW'(1);
                        end
                        if (last_word) begin
                            state_d = ST_IDLE;
                        end else begin
                            word_d  = word_q + WCW'(1);
                            state_d = ST_RD_ISSUE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            inc_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            word_q     <= '0;
            abyte_q    <= '0;
            dbyte_q    <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= '0;
            wr_pulse_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            inc_q      <= inc_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            abyte_q    <= abyte_d;
            dbyte_q    <= dbyte_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            wr_pulse_q <= wr_pulse_d;
            last_q     <= last_d;
        end
    end

    assign rd_shift = rdata_q >> {dbyte_q, 3'b000};

    always_comb begin
        reply_out = 8'h00;
        reply_rdy = 1'b0;
        reply_end = 1'b0;
        if (state_q == ST_REPLY_STATUS) begin
            reply_out = status_q;
            reply_rdy = 1'b1;
            reply_end = is_wr_q || err_q;
        end else if (state_q == ST_REPLY_DATA) begin
            reply_out = rd_shift[7:0];
            reply_rdy = 1'b1;
            reply_end = last_byte && last_word;
        end
    end

    assign reg_addr    = addr_q;
    assign reg_wdata   = wdata_q;
    assign reg_wr      = wr_pulse_q;
    assign reg_rd      = (state_q == ST_RD_ISSUE);
    assign timeout_evt = tmo_expire;
    assign cmd_dropped = cmd_wr &&
                         ((state_q == ST_REPLY_STATUS) ||
                          (state_q == ST_RD_ISSUE) ||
                          (state_q == ST_RD_WAIT) ||
                          (state_q == ST_REPLY_DATA));

endmodule

// File: tb/tb_reg_burst_manager.sv
// Directed self-checking bench for reg_burst_manager.
// Ports: none (top-level bench).
module tb_reg_burst_manager;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_wr;
    logic [7:0]  cmd_in;
    logic [7:0]  reply_out;
    logic        reply_rdy;
    logic        reply_ack;
    logic        reply_end;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata = 32'h0;
    logic        timeout_evt;
    logic        cmd_dropped;

    int errors = 0;
    int checks = 0;

    logic [15:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [15:0] rd_a[$];
    int          tmo_cnt = 0;
    int          drop_cnt = 0;

    reg_burst_manager #(
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_wr      (cmd_wr),
        .cmd_in      (cmd_in),
        .reply_out   (reply_out),
        .reply_rdy   (reply_rdy),
        .reply_ack   (reply_ack),
        .reply_end   (reply_end),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .timeout_evt (timeout_evt),
        .cmd_dropped (cmd_dropped)
    );

    always #5 clk = ~clk;

    // Register stub: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_rd) reg_rdata <= 32'(reg_addr) + 32'd100;
    end

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_a.push_back(reg_addr);
            wr_d.push_back(reg_wdata);
        end
        if (reg_rd) rd_a.push_back(reg_addr);
        if (timeout_evt) tmo_cnt++;
        if (cmd_dropped) drop_cnt++;
    end

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        tmo_cnt = 0;
        drop_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmd_wr = 1'b1;
        cmd_in = b;
        @(posedge clk);
        #1;
        cmd_wr = 1'b0;
    endtask

    task automatic get_reply(output logic [7:0] b, output logic e,
                             output bit got);
        got = 1'b0;
        b = 8'h00;
        e = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (reply_rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            b = reply_out;
            e = reply_end;
            reply_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        reply_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_wr = 1'b0;
        cmd_in = 8'h00;
        reply_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (reply_rdy !== 1'b0 || reply_out !== 8'h00 || reply_end !== 1'b0)
            begin errors++;
            $display("FAIL reset_reply: got rdy=%b out=%h end=%b want 0 00 0",
                     reply_rdy, reply_out, reply_end); end
        checks++;
        if (reg_addr !== 16'h0 || reg_wdata !== 32'h0)
            begin errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0 0",
                     reg_addr, reg_wdata); end
        checks++;
        if (reg_wr !== 1'b0 || reg_rd !== 1'b0)
            begin errors++;
            $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0",
                     reg_wr, reg_rd); end
        checks++;
        if (timeout_evt !== 1'b0 || cmd_dropped !== 1'b0)
            begin errors++;
            $display("FAIL reset_events: got tmo=%b drop=%b want 0 0",
                     timeout_evt, cmd_dropped); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_single_write();
        logic [7:0] b;
        logic       e;
        bit         got;
        logic [7:0] frm [8] = '{8'hAA, 8'h01, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_logs();
        foreach (frm[i]) send_byte(frm[i]);
        get_reply(b, e, got);
        checks++;
        if (!got || b !== 8'h5A || e !== 1'b1) begin errors++;
            $display("FAIL write_status: got %0d/%h end %b want 1/5a end 1",
                     got, b, e); end
        checks++;
        if (wr_a.size() != 1) begin errors++;
            $display("FAIL write_count: got %0d want 1", wr_a.size()); end
        else begin
            checks++;
            if (wr_a[0] !== 16'h1234 || wr_d[0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL write_bus: got %h/%h want 1234/deadbeef",
                         wr_a[0], wr_d[0]); end
        end
    endtask

    task automatic test_burst_read();
        logic [7:0]  b;
        logic        e;
        bit          got;
        logic [31:0] w;
        logic [7:0]  eb;
        logic        ee;
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h32);
        send_byte(8'h00);
        send_byte(8'h01);
        get_reply(b, e, got);
        checks++;
        if (!got || b !== 8'h5A || e !== 1'b0) begin errors++;
            $display("FAIL read_status: got %0d/%h end %b want 1/5a end 0",
                     got, b, e); end
        for (int wi = 0; wi < 4; wi++) begin
            for (int bi = 0; bi < 4; bi++) begin
                w  = 32'h100 + 32'(wi) + 32'd100;
                eb = 8'(w >> (8 * bi));
                ee = (wi == 3) && (bi == 3);
                get_reply(b, e, got);
                checks++;
                if (!got || b !== eb || e !== ee) begin errors++;
                    $display("FAIL read_byte w%0d b%0d: got %0d/%h end %b want 1/%h end %b",
                             wi, bi, got, b, e, eb, ee); end
            end
        end
        checks++;
        if (rd_a.size() != 4) begin errors++;
            $display("FAIL read_strobes: got %0d want 4", rd_a.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_a[i] !== 16'h0100 + 16'(i)) begin errors++;
                    $display("FAIL read_addr%0d: got %h want %h",
                             i, rd_a[i], 16'h0100 + 16'(i)); end
            end
        end
        @(negedge clk);
        checks++;
        if (reply_rdy !== 1'b0 || wr_a.size() != 0) begin errors++;
            $display("FAIL read_done: got rdy=%b writes=%0d want 0 0",
                     reply_rdy, wr_a.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bad_type();
        logic [7:0] b;
        logic       e;
        bit         got;
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h0C);
        get_reply(b, e, got);
        checks++;
        if (!got || b !== 8'hE1 || e !== 1'b1) begin errors++;
            $display("FAIL badtype_status: got %0d/%h end %b want 1/e1 end 1",
                     got, b, e); end
        send_byte(8'h01);
        send_byte(8'h34);
        send_byte(8'h12);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (reply_rdy !== 1'b0) begin errors++;
            $display("FAIL badtype_idle: got rdy=%b want 0", reply_rdy); end
        checks++;
        if (wr_a.size() != 0 || rd_a.size() != 0 || drop_cnt != 0) begin
            errors++;
            $display("FAIL badtype_bus: got wr=%0d rd=%0d drop=%0d want 0 0 0",
                     wr_a.size(), rd_a.size(), drop_cnt); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall_drop();
        logic [7:0] b;
        logic       e;
        bit         got;
        int         bad;
        logic [7:0] frm [8] = '{8'hAA, 8'h01, 8'h00, 8'h20,
                                 8'h01, 8'h00, 8'h00, 8'h00};
        clear_logs();
        foreach (frm[i]) send_byte(frm[i]);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (reply_rdy) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin errors++;
            $display("FAIL stall_wait: got no reply want reply_rdy"); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cmd_wr = (i == 4);
            cmd_in = 8'hAA;
            @(negedge clk);
            if (reply_rdy !== 1'b1 || reply_out !== 8'h5A ||
                reply_end !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        cmd_wr = 1'b0;
        checks++;
        if (bad != 0) begin errors++;
            $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
        checks++;
        if (drop_cnt != 1) begin errors++;
            $display("FAIL stall_dropped: got %0d pulses want 1", drop_cnt); end
        get_reply(b, e, got);
        checks++;
        if (!got || b !== 8'h5A || e !== 1'b1) begin errors++;
            $display("FAIL stall_status: got %0d/%h end %b want 1/5a end 1",
                     got, b, e); end
        checks++;
        if (wr_a.size() != 1 || wr_a[0] !== 16'h2000 || wr_d[0] !== 32'h1)
            begin errors++;
            $display("FAIL stall_write: got n=%0d want 1 write 2000/00000001",
                     wr_a.size()); end
        @(negedge clk);
        checks++;
        if (reply_rdy !== 1'b0) begin errors++;
            $display("FAIL stall_idle: got rdy=%b want 0", reply_rdy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        logic       e;
        bit         got;
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hEF);
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (tmo_cnt != 0) begin errors++;
            $display("FAIL timeout_early: got %0d pulses want 0", tmo_cnt); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tmo_cnt != 1 || wr_a.size() != 0) begin errors++;
            $display("FAIL timeout_fire: got tmo=%0d wr=%0d want 1 0",
                     tmo_cnt, wr_a.size()); end
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        get_reply(b, e, got);
        checks++;
        if (!got || b !== 8'h5A || e !== 1'b1 || wr_a.size() != 1) begin
            errors++;
            $display("FAIL timeout_recover: got %0d/%h end %b wr=%0d want 1/5a 1 1",
                     got, b, e, wr_a.size()); end
        else begin
            checks++;
            if (wr_a[0] !== 16'h5678 || wr_d[0] !== 32'h11223344) begin
                errors++;
                $display("FAIL timeout_bus: got %h/%h want 5678/11223344",
                         wr_a[0], wr_d[0]); end
        end
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h01);
        repeat (15) @(posedge clk);
        #1;
        send_byte(8'h9A);
        send_byte(8'h00);
        send_byte(8'h0D);
        send_byte(8'h0C);
        send_byte(8'h0B);
        send_byte(8'h0A);
        get_reply(b, e, got);
        checks++;
        if (tmo_cnt != 0 || !got || b !== 8'h5A || wr_a.size() != 1) begin
            errors++;
            $display("FAIL timeout_edge: got tmo=%0d reply=%0d/%h wr=%0d want 0 1/5a 1",
                     tmo_cnt, got, b, wr_a.size()); end
        else begin
            checks++;
            if (wr_a[0] !== 16'h009A || wr_d[0] !== 32'h0A0B0C0D) begin
                errors++;
                $display("FAIL timeout_edge_bus: got %h/%h want 009a/0a0b0c0d",
                         wr_a[0], wr_d[0]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h33);
        send_byte(8'h00);
        send_byte(8'h30);
        repeat (4) send_byte(8'h11);
        repeat (4) send_byte(8'h22);
        @(posedge clk);
        #1;
        checks++;
        if (reg_addr !== 16'h3002) begin errors++;
            $display("FAIL midburst_addr: got %h want 3002", reg_addr); end
        cmd_wr = 1'b1;
        cmd_in = 8'h33;
        #2;
        reset_n = 1'b0;
        cmd_wr = 1'b0;
        #1;
        checks++;
        if (reg_wr !== 1'b0 || reg_addr !== 16'h0 || reply_rdy !== 1'b0)
            begin errors++;
            $display("FAIL midburst_reset: got wr=%b addr=%h rdy=%b want 0 0000 0",
                     reg_wr, reg_addr, reply_rdy); end
        checks++;
        if (wr_a.size() != 2) begin errors++;
            $display("FAIL midburst_count: got %0d want 2", wr_a.size()); end
        else begin
            checks++;
            if (wr_a[0] !== 16'h3000 || wr_d[0] !== 32'h11111111 ||
                wr_a[1] !== 16'h3001 || wr_d[1] !== 32'h22222222) begin
                errors++;
                $display("FAIL midburst_words: got %h/%h %h/%h want 3000/11111111 3001/22222222",
                         wr_a[0], wr_d[0], wr_a[1], wr_d[1]); end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_a.size() != 2 || reg_addr !== 16'h0 || reply_rdy !== 1'b0)
            begin errors++;
            $display("FAIL midburst_after: got wr=%0d addr=%h rdy=%b want 2 0000 0",
                     wr_a.size(), reg_addr, reply_rdy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_bad_type();
        test_stall_drop();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_burst_manager.md
Name: reg_burst_manager

Overview:
- Host-command register master; successor to the fixed 16/32-bit single-access register manager.
- Parses framed byte commands from the FX2 bidirectional FIFO interface and drives a separate-read/write internal register bus.
- Parametrised address/data byte widths, burst access with optional auto-increment, status-byte replies, and mid-frame timeout recovery.

Parameters:
- ADDR_BYTES, 2, address bytes per frame, LSB first; reg_addr width = 8*ADDR_BYTES.
- DATA_BYTES, 4, bytes per register word, LSB first; reg_wdata/reg_rdata width = 8*DATA_BYTES.
- MAGIC, 8'hAA, frame start byte.
- READ_LATENCY, 1, cycles from the reg_rd pulse to reg_rdata valid (>=1).
- TIMEOUT, 1024, idle cycles allowed between command bytes mid-frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_wr  in  1  command byte valid strobe.
- cmd_in  in  8  command byte.
- reply_out  out  8  reply byte; 0 when reply_rdy=0.
- reply_rdy  out  1  reply_out valid.
- reply_ack  in  1  host consumed the byte; ignored when reply_rdy=0.
- reply_end  out  1  high with the last byte of a reply.
- reg_addr  out  8*ADDR_BYTES  register address; holds its last value when idle.
- reg_wdata  out  8*DATA_BYTES  write data, valid with reg_wr.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  8*DATA_BYTES  read data.
- timeout_evt  out  1  one-cycle pulse when a frame is aborted by timeout.
- cmd_dropped  out  1  one-cycle pulse when cmd_wr arrives while the FSM is not accepting bytes.

Behaviour:
- Reset: state IDLE. All outputs and internal registers are 0, including reg_addr. reg_wr and reg_rd clear immediately; an in-flight frame is discarded.
- Frame format: MAGIC, TYPE, ADDR_BYTES address bytes, then count*DATA_BYTES data bytes (writes only).
- TYPE byte fields:
  - bit0: 1=write, 0=read.
  - bit1: auto-increment address by 1 after each word.
  - bits3:2: must be 00.
  - bits7:4: count-1, giving bursts of 1..16 words.
- FSM states: IDLE, TYPE, ADDR, WDATA, RD_ISSUE, RD_WAIT, REPLY_STATUS, REPLY_DATA.
- IDLE: on cmd_wr with cmd_in==MAGIC go to TYPE. Other bytes are silently ignored and do not count as dropped.
- TYPE: latch the fields. If bits3:2 != 00, status = 8'hE1 and go to REPLY_STATUS with no bus access. Otherwise status = 8'h5A and go to ADDR.
- ADDR: shift in ADDR_BYTES bytes, LSB first. Then go to WDATA (write) or REPLY_STATUS (read).
- WDATA: byte counter accepts one byte per cmd_wr with no back-pressure.
  - After the final byte of each word, reg_wr pulses on the next cycle with the current reg_addr/reg_wdata.
  - Auto-increment applies to reg_addr on the cycle after the pulse; address wraps modulo 2^(8*ADDR_BYTES).
  - Byte acceptance continues during the pulse; back-to-back words are legal.
  - After the final word's pulse, go to REPLY_STATUS.
- REPLY_STATUS: reply_rdy=1, reply_out=status. reply_end=1 for a write or an error frame. On reply_ack:
  - write or error: go to IDLE;
  - read: go to RD_ISSUE.
- RD_ISSUE: reg_rd pulses for 1 cycle, then go to RD_WAIT.
- RD_WAIT: capture reg_rdata exactly READ_LATENCY cycles after the reg_rd cycle, then go to REPLY_DATA. reply_rdy=0 throughout.
- REPLY_DATA: emit DATA_BYTES bytes LSB first, advancing one byte per acknowledged cycle (reply_rdy && reply_ack).
  - After the last byte of a word, auto-increment if enabled, then go to RD_ISSUE for the next word.
  - reply_end=1 only on the last byte of the last word; acknowledging it returns to IDLE.
- Timeout: a counter clears on each accepted cmd_wr in TYPE/ADDR/WDATA and increments otherwise in those states.
  - At TIMEOUT: go to IDLE, pulse timeout_evt, no reg_wr for a partial word. Completed words stay written.
- cmd_dropped: pulses for any cmd_wr in REPLY_STATUS, RD_ISSUE, RD_WAIT or REPLY_DATA; the byte is discarded.
- Simultaneous events: cmd_wr on the same cycle the timeout expires counts as accepted, and the timeout does not fire.

Decomposition:
- Shared package reg_burst_pkg: state enum, STATUS_OK=8'h5A, STATUS_BADTYPE=8'hE1, TYPE bit-position constants, MAX_BURST=16.
- One sub-module, reg_cmd_timeout: parametrised idle counter with clear/enable inputs and an expire pulse output; bypassed when TIMEOUT=0.

Test Plan:
- Single write: AA,01,34,12,EF,BE,AD,DE -> one reg_wr with addr 16'h1234, data 32'hDEADBEEF; reply 5A with reply_end.
- Burst read with auto-increment: AA,32,00,01 (read, auto-inc, count 4); reg_rdata = addr+100 -> reg_rd at 0100..0103; reply 5A then 16 bytes LSB first; reply_end only on byte 16.
- Bad type: AA,0C -> reply E1 with reply_end, no reg_wr/reg_rd; subsequent bytes before the next AA ignored.
- Timeout: TIMEOUT=16; AA,01,34,12,EF then 16 idle cycles -> timeout_evt pulse, no reg_wr; the next valid frame succeeds.
- Reply stall and drop: withhold reply_ack for 10 cycles -> reply_out stable; cmd_wr during the stall -> cmd_dropped pulse, reply unaffected.
- Reset mid-burst: assert reset_n=0 during a 4-word write after word 2 -> reg_wr 0 immediately, state IDLE, reg_addr 0; words 1-2 already written.
